lc3_mem_arbiter: RTL and testbench
==================================

Name: lc3_mem_arbiter

Overview:
- Sequences and shares the single-port LC-3 memory between two requesters:
  - the CPU control FSM, for fetch, load and store;
  - the program loader/debug port, for boot-time preload of instructions.
- Fixed priority favours the loader, with a starvation guard for the CPU.
- Each access latches address, data and write-enable, waits a fixed memory latency, then returns read data with a one-cycle done pulse.
- Sits between the control/loader blocks and the memory macro, replacing direct MAR/MDR special-input writes.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- MEM_LAT, 1, memory access cycles (1..15).
- STARVE_MAX, 4, consecutive loader grants tolerated while CPU is waiting (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU access request; held until cpu_done.
- cpu_we  in  1  CPU write (1) / read (0).
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  CPU owns memory.
- cpu_done  out  1  one-cycle completion pulse to CPU.
- ldr_req  in  1  loader request.
- ldr_we  in  1  loader write/read.
- ldr_addr  in  ADDR_W  loader address.
- ldr_wdata  in  DATA_W  loader write data.
- ldr_gnt  out  1  loader owns memory.
- ldr_done  out  1  one-cycle completion pulse to loader.
- rdata  out  DATA_W  read data; valid while either done is high.
- mem_addr  out  ADDR_W  to memory.
- mem_wdata  out  DATA_W  to memory.
- mem_we  out  1  memory write strobe.
- mem_rdata  in  DATA_W  from memory.
- busy  out  1  arbiter not in IDLE.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, starve_cnt=0, lat_cnt=0;
  - all outputs 0, including rdata, mem_addr and mem_wdata.
- States: IDLE, ACCESS, RESP.
- IDLE: samples requests at each rising edge.
  - Loader wins if ldr_req=1, unless cpu_req=1 and starve_cnt==STARVE_MAX; then the CPU wins.
  - On grant at edge k:
    - latch addr/we/wdata of the winner;
    - assert its gnt;
    - lat_cnt=MEM_LAT;
    - go to ACCESS.
- starve_cnt update, applied at each grant:
  - loader grant with cpu_req=1: increment, saturating at STARVE_MAX;
  - loader grant with cpu_req=0: clear to 0;
  - CPU grant: clear to 0.
- ACCESS:
  - mem_addr/mem_wdata are driven from the latches.
  - mem_we=1 only in the first ACCESS cycle, and only for writes (exactly one cycle per write).
  - lat_cnt decrements each edge.
  - At the edge where lat_cnt==1: capture mem_rdata into rdata and go to RESP.
  - Done therefore appears at edge k+MEM_LAT.
- RESP:
  - owner's done=1 for exactly one cycle; gnt stays 1.
  - rdata holds until the next capture. On writes it is still updated with mem_rdata.
  - Next edge: IDLE, gnt=0.
- Gap: at least one IDLE cycle between accesses; a grant edge occurs no earlier than done edge + 2.
- Requester contract:
  - keep req/addr/data stable until done;
  - deassert req by the edge after done, unless it is issuing another access.
- Requests dropped mid-access are ignored; the latched access completes.
- Exactly one gnt is high at a time; busy = gnt of either requester.
- mem_addr/mem_wdata hold their last values in IDLE; mem_we=0 in IDLE and in RESP.
- Reset asserted mid-access:
  - immediately mem_we=0, gnt=0, done=0;
  - no done is produced for the aborted access.

Optional Feature:
- Macro: LC3_ARB_STATS_EN.
- Defined: adds outputs cpu_grant_cnt[15:0] and ldr_grant_cnt[15:0].
  - Each increments on its port's grant edge and saturates at 16'hFFFF.
  - Both clear on reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold reset_n=0 with random inputs -> all outputs 0, busy=0; release -> still idle with no request.
- CPU write, MEM_LAT=1: cpu_req=1, we=1, addr=16'h0001, wdata=16'hE203 -> cpu_gnt at edge k; mem_we=1 for one cycle with those values; cpu_done at edge k+1 only.
- Loader read, MEM_LAT=3: mem_rdata=16'h3200 at addr 16'h0002 -> ldr_done at edge k+3, rdata=16'h3200, mem_we never high.
- Contention, STARVE_MAX=4: both requests held continuously, re-requesting after each done -> grant order L,L,L,L,C,L,L,L,L,C; gnt signals never overlap.
- Reset mid-write: assert reset_n=0 during ACCESS -> mem_we and ldr_gnt drop asynchronously, no ldr_done; after release, the next request is served normally.
- With LC3_ARB_STATS_EN: 3 CPU and 5 loader accesses -> cpu_grant_cnt=3, ldr_grant_cnt=5; reset clears both to 0.

Source files
------------

// File: rtl/lc3_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// lc3_mem_arbiter_if
// Bundles the requester handshakes (CPU control FSM and program loader) and
// the single-port memory macro bus around lc3_mem_arbiter.
//
//   cpu_*     : CPU request / grant / done handshake and access fields
//   ldr_*     : loader request / grant / done handshake and access fields
//   rdata     : read data returned to whichever requester sees done
//   mem_*     : memory macro address, write data, write strobe, read data
//   busy      : arbiter is serving an access
//
// Modports:
//   slave  : the arbiter's view (requests in, grants/done/memory bus out)
//   master : the environment's view (requesters plus memory model)
//
// Optional macro LC3_ARB_STATS_EN adds the grant counters cpu_grant_cnt and
// ldr_grant_cnt to both modports.
// ---------------------------------------------------------------------------
interface lc3_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_done;

    logic              ldr_req;
    logic              ldr_we;
    logic [ADDR_W-1:0] ldr_addr;
    logic [DATA_W-1:0] ldr_wdata;
    logic              ldr_gnt;
    logic              ldr_done;

    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

`ifdef LC3_ARB_STATS_EN
    logic [15:0]       cpu_grant_cnt;
    logic [15:0]       ldr_grant_cnt;
`endif

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  mem_rdata,
        output cpu_gnt, cpu_done, ldr_gnt, ldr_done,
        output rdata, mem_addr, mem_wdata, mem_we, busy
`ifdef LC3_ARB_STATS_EN
        , output cpu_grant_cnt, ldr_grant_cnt
`endif
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output mem_rdata,
        input  cpu_gnt, cpu_done, ldr_gnt, ldr_done,
        input  rdata, mem_addr, mem_wdata, mem_we, busy
`ifdef LC3_ARB_STATS_EN
        , input cpu_grant_cnt, ldr_grant_cnt
`endif
    );
endinterface

// File: rtl/lc3_mem_arbiter.sv
// ---------------------------------------------------------------------------
// lc3_mem_arbiter
// Shares the single-port LC-3 memory between the CPU control FSM and the
// program loader/debug port. The loader has fixed priority; after
// STARVE_MAX consecutive loader grants taken while the CPU was waiting, the
// CPU wins the next arbitration. Each access latches the winner's address,
// write data and write enable, pulses mem_we for one cycle on writes, waits
// MEM_LAT cycles, captures mem_rdata into rdata and pulses the owner's done.
//
// Ports:
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset; clears state and all outputs
//   bus      : lc3_mem_arbiter_if.slave (requester handshakes + memory bus)
//
// Parameters: ADDR_W, DATA_W, MEM_LAT (1..15), STARVE_MAX (1..15).
//
// Optional macro LC3_ARB_STATS_EN: adds saturating 16-bit grant counters
// cpu_grant_cnt / ldr_grant_cnt on the interface.
// ---------------------------------------------------------------------------
module lc3_mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    lc3_mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_e            state_r,      state_s;
    logic [3:0]        lat_cnt_r,    lat_cnt_s;
    logic [3:0]        starve_cnt_r, starve_cnt_s;
    logic              owner_ldr_r,  owner_ldr_s;
    logic [ADDR_W-1:0] mem_addr_r,   mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_r,  mem_wdata_s;
    logic              mem_we_r,     mem_we_s;
    logic              cpu_gnt_r,    cpu_gnt_s;
    logic              ldr_gnt_r,    ldr_gnt_s;
    logic              cpu_done_r,   cpu_done_s;
    logic              ldr_done_r,   ldr_done_s;
    logic [DATA_W-1:0] rdata_r,      rdata_s;
    logic              busy_r,       busy_s;
    logic              ldr_wins_s;
    logic              cpu_wins_s;

    // Arbitration: loader first, unless the CPU has waited through STARVE_MAX loader grants
    always_comb begin
        ldr_wins_s = 1'b0;
        cpu_wins_s = 1'b0;
        if (state_r == ST_IDLE) begin
            if (bus.ldr_req && !(bus.cpu_req && (starve_cnt_r == STARVE_LIM))) begin
                ldr_wins_s = 1'b1;
            end else if (bus.cpu_req) begin
                cpu_wins_s = 1'b1;
            end else begin
                ldr_wins_s = 1'b0;
                cpu_wins_s = 1'b0;
            end
        end else begin
            ldr_wins_s = 1'b0;
            cpu_wins_s = 1'b0;
        end
    end

    // Next-state and next-output logic for the IDLE/ACCESS/RESP sequencer
    always_comb begin
        state_s      = state_r;
        lat_cnt_s    = lat_cnt_r;
        starve_cnt_s = starve_cnt_r;
        owner_ldr_s  = owner_ldr_r;
        mem_addr_s   = mem_addr_r;
        mem_wdata_s  = mem_wdata_r;
        mem_we_s     = 1'b0;
        cpu_gnt_s    = cpu_gnt_r;
        ldr_gnt_s    = ldr_gnt_r;
        cpu_done_s   = 1'b0;
        ldr_done_s   = 1'b0;
        rdata_s      = rdata_r;

        case (state_r)
            ST_IDLE: begin
                if (ldr_wins_s) begin
                    state_s     = ST_ACCESS;
                    lat_cnt_s   = LAT_INIT;
                    owner_ldr_s = 1'b1;
                    mem_addr_s  = bus.ldr_addr;
                    mem_wdata_s = bus.ldr_wdata;
                    mem_we_s    = bus.ldr_we;
                    ldr_gnt_s   = 1'b1;
                    cpu_gnt_s   = 1'b0;
                    // Only loader grants that made the CPU wait count towards starvation
                    if (bus.cpu_req) begin
                        if (starve_cnt_r < STARVE_LIM) begin
                            starve_cnt_s = starve_cnt_r + 4'd1;
                        end else begin
                            starve_cnt_s = starve_cnt_r;
                        end
                    end else begin
                        starve_cnt_s = 4'd0;
                    end
                end else if (cpu_wins_s) begin
                    state_s      = ST_ACCESS;
                    lat_cnt_s    = LAT_INIT;
                    owner_ldr_s  = 1'b0;
                    mem_addr_s   = bus.cpu_addr;
                    mem_wdata_s  = bus.cpu_wdata;
                    mem_we_s     = bus.cpu_we;
                    cpu_gnt_s    = 1'b1;
                    ldr_gnt_s    = 1'b0;
                    starve_cnt_s = 4'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                // mem_we defaults low here, so a write strobe lasts only the first ACCESS cycle
                lat_cnt_s = lat_cnt_r - 4'd1;
                if (lat_cnt_r == 4'd1) begin
                    state_s    = ST_RESP;
                    rdata_s    = bus.mem_rdata;
                    cpu_done_s = ~owner_ldr_r;
                    ldr_done_s = owner_ldr_r;
                end else begin
                    state_s = ST_ACCESS;
                end
            end
            ST_RESP: begin
                state_s   = ST_IDLE;
                cpu_gnt_s = 1'b0;
                ldr_gnt_s = 1'b0;
            end
            default: begin
                state_s   = ST_IDLE;
                cpu_gnt_s = 1'b0;
                ldr_gnt_s = 1'b0;
            end
        endcase

        busy_s = cpu_gnt_s | ldr_gnt_s;
    end

    // State and output registers; reset drops strobes and grants immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            lat_cnt_r    <= 4'd0;
            starve_cnt_r <= 4'd0;
            owner_ldr_r  <= 1'b0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_wdata_r  <= {DATA_W{1'b0}};
            mem_we_r     <= 1'b0;
            cpu_gnt_r    <= 1'b0;
            ldr_gnt_r    <= 1'b0;
            cpu_done_r   <= 1'b0;
            ldr_done_r   <= 1'b0;
            rdata_r      <= {DATA_W{1'b0}};
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            lat_cnt_r    <= lat_cnt_s;
            starve_cnt_r <= starve_cnt_s;
            owner_ldr_r  <= owner_ldr_s;
            mem_addr_r   <= mem_addr_s;
            mem_wdata_r  <= mem_wdata_s;
            mem_we_r     <= mem_we_s;
            cpu_gnt_r    <= cpu_gnt_s;
            ldr_gnt_r    <= ldr_gnt_s;
            cpu_done_r   <= cpu_done_s;
            ldr_done_r   <= ldr_done_s;
            rdata_r      <= rdata_s;
            busy_r       <= busy_s;
        end
    end

    assign bus.cpu_gnt   = cpu_gnt_r;
    assign bus.ldr_gnt   = ldr_gnt_r;
    assign bus.cpu_done  = cpu_done_r;
    assign bus.ldr_done  = ldr_done_r;
    assign bus.rdata     = rdata_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.busy      = busy_r;

`ifdef LC3_ARB_STATS_EN
    logic [15:0] cpu_grant_cnt_r;
    logic [15:0] ldr_grant_cnt_r;

    // Saturating per-port grant counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_grant_cnt_r <= 16'd0;
            ldr_grant_cnt_r <= 16'd0;
        end else begin
            if (cpu_wins_s && (cpu_grant_cnt_r != 16'hFFFF)) begin
                cpu_grant_cnt_r <= cpu_grant_cnt_r + 16'd1;
            end else begin
                cpu_grant_cnt_r <= cpu_grant_cnt_r;
            end
            if (ldr_wins_s && (ldr_grant_cnt_r != 16'hFFFF)) begin
                ldr_grant_cnt_r <= ldr_grant_cnt_r + 16'd1;
            end else begin
                ldr_grant_cnt_r <= ldr_grant_cnt_r;
            end
        end
    end

    assign bus.cpu_grant_cnt = cpu_grant_cnt_r;
    assign bus.ldr_grant_cnt = ldr_grant_cnt_r;
`endif

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lc3_mem_arbiter
// Bench for lc3_mem_arbiter. u_dut runs with MEM_LAT=1 / STARVE_MAX=4 against
// a small behavioural memory; u_dut3 runs with MEM_LAT=3 against a fixed
// read-data pattern. Expected accesses are queued per port when driven and
// popped by a negedge monitor when the matching done pulse appears.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lc3_mem_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lc3_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
    lc3_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

    lc3_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .STARVE_MAX(4)) u_dut (
        .clk(clk), .reset_n(reset_n), .bus(bus1)
    );
    lc3_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .bus(bus3)
    );

    // Behavioural memory for u_dut: word i starts as 16'hA500 | i
    logic [15:0] mem1 [0:255];
    initial for (int i = 0; i < 256; i++) mem1[i] = 16'hA500 | 16'(i);
    always @(posedge clk) if (bus1.mem_we) mem1[bus1.mem_addr[7:0]] <= bus1.mem_wdata;
    assign bus1.mem_rdata = mem1[bus1.mem_addr[7:0]];
    assign bus3.mem_rdata = (bus3.mem_addr[7:0] == 8'h02) ? 16'h3200 : 16'h0000;

    int checks = 0;
    int errors = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=event expected=none", name);
    endtask

    typedef struct {
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } exp_t;

    typedef struct {
        bit          is_ldr;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } vec_t;

    exp_t cpu_q[$];
    exp_t ldr_q[$];
    byte  grant_log[$];
    int   cpu_grants = 0;
    int   ldr_grants = 0;
    int   we3_cnt    = 0;

    // Scoreboard monitor for u_dut, sampled on the falling edge
    initial begin : monitor
        bit   prev_busy = 1'b0;
        bit   prev_done = 1'b0;
        bit   done_seen = 1'b0;
        int   grant_cyc = 0;
        int   done_cyc  = 0;
        int   we_cnt    = 0;
        logic gnt_now;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && bus3.mem_we) we3_cnt++;
            if (!reset_n) begin
                cpu_q.delete();
                ldr_q.delete();
                prev_busy  = 1'b0;
                prev_done  = 1'b0;
                done_seen  = 1'b0;
                we_cnt     = 0;
                cpu_grants = 0;
                ldr_grants = 0;
            end else begin
                gnt_now = bus1.cpu_gnt | bus1.ldr_gnt;
                check1("gnt_overlap", bus1.cpu_gnt & bus1.ldr_gnt, 1'b0);
                check1("busy", bus1.busy, gnt_now);
                check1("done_both", bus1.cpu_done & bus1.ldr_done, 1'b0);
                if (gnt_now && !prev_busy) begin
                    grant_cyc = cyc;
                    we_cnt    = 0;
                    grant_log.push_back(bus1.ldr_gnt ? 8'h4C : 8'h43);
                    if (bus1.ldr_gnt) ldr_grants++; else cpu_grants++;
                    if (done_seen) check1("grant_gap", (cyc - done_cyc) >= 2, 1'b1);
                end
                if (bus1.mem_we) begin
                    we_cnt++;
                    if (bus1.cpu_gnt && cpu_q.size() != 0) begin
                        check16("cpu_mem_addr", bus1.mem_addr, cpu_q[0].addr);
                        check16("cpu_mem_wdata", bus1.mem_wdata, cpu_q[0].wdata);
                    end else if (bus1.ldr_gnt && ldr_q.size() != 0) begin
                        check16("ldr_mem_addr", bus1.mem_addr, ldr_q[0].addr);
                        check16("ldr_mem_wdata", bus1.mem_wdata, ldr_q[0].wdata);
                    end else begin
                        fail_now("mem_we_orphan");
                    end
                end
                if (bus1.cpu_done || bus1.ldr_done) begin
                    check1("done_pulse", prev_done, 1'b0);
                    if (bus1.cpu_done ? (cpu_q.size() == 0) : (ldr_q.size() == 0)) begin
                        fail_now(bus1.cpu_done ? "cpu_done_unexpected" : "ldr_done_unexpected");
                    end else begin
                        e = bus1.cpu_done ? cpu_q.pop_front() : ldr_q.pop_front();
                        check16("rdata", bus1.rdata, e.rdata);
                        check16("done_latency", 16'(cyc - grant_cyc), 16'd1);
                        check16("we_cycles", 16'(we_cnt), e.we ? 16'd1 : 16'd0);
                        check1("gnt_in_resp", bus1.cpu_done ? bus1.cpu_gnt : bus1.ldr_gnt, 1'b1);
                    end
                    done_cyc  = cyc;
                    done_seen = 1'b1;
                end
                prev_busy = gnt_now;
                prev_done = bus1.cpu_done | bus1.ldr_done;
            end
        end
    end

    // One access on u_dut: queue the expectation, raise req, wait (bounded) for done
    task automatic do_access(input bit is_ldr, input bit we, input logic [15:0] addr,
                             input logic [15:0] wdata, input logic [15:0] rdata,
                             input bit release_req);
        exp_t e;
        int   n;
        bit   got;
        e = '{we: we, addr: addr, wdata: wdata, rdata: rdata};
        if (is_ldr) begin
            bus1.ldr_we = we; bus1.ldr_addr = addr; bus1.ldr_wdata = wdata;
            ldr_q.push_back(e);
            bus1.ldr_req = 1'b1;
        end else begin
            bus1.cpu_we = we; bus1.cpu_addr = addr; bus1.cpu_wdata = wdata;
            cpu_q.push_back(e);
            bus1.cpu_req = 1'b1;
        end
        n   = 0;
        got = 1'b0;
        while (!got && n < 100) begin
            @(negedge clk); #1;
            n++;
            got = is_ldr ? bus1.ldr_done : bus1.cpu_done;
        end
        if (!got) fail_now(is_ldr ? "ldr_timeout" : "cpu_timeout");
        if (release_req) begin
            if (is_ldr) bus1.ldr_req = 1'b0; else bus1.cpu_req = 1'b0;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check1({tag, "_cpu_gnt"}, bus1.cpu_gnt, 1'b0);
        check1({tag, "_ldr_gnt"}, bus1.ldr_gnt, 1'b0);
        check1({tag, "_cpu_done"}, bus1.cpu_done, 1'b0);
        check1({tag, "_ldr_done"}, bus1.ldr_done, 1'b0);
        check1({tag, "_mem_we"}, bus1.mem_we, 1'b0);
        check1({tag, "_busy"}, bus1.busy, 1'b0);
        check16({tag, "_rdata"}, bus1.rdata, 16'h0000);
        check16({tag, "_mem_addr"}, bus1.mem_addr, 16'h0000);
        check16({tag, "_mem_wdata"}, bus1.mem_wdata, 16'h0000);
        check1({tag, "_busy3"}, bus3.busy, 1'b0);
        check16({tag, "_mem_addr3"}, bus3.mem_addr, 16'h0000);
    endtask

    initial begin : stim
        vec_t  vecs [9];
        string exp_order;
        int    n;
        int    g;

        vecs[0] = '{1'b0, 1'b1, 16'h0001, 16'hE203, 16'hA501};
        vecs[1] = '{1'b0, 1'b0, 16'h0001, 16'h0000, 16'hE203};
        vecs[2] = '{1'b1, 1'b1, 16'h0002, 16'h3200, 16'hA502};
        vecs[3] = '{1'b1, 1'b0, 16'h0002, 16'h0000, 16'h3200};
        vecs[4] = '{1'b0, 1'b0, 16'h00FF, 16'h0000, 16'hA5FF};
        vecs[5] = '{1'b1, 1'b1, 16'h0010, 16'h1234, 16'hA510};
        vecs[6] = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h1234};
        vecs[7] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
        vecs[8] = '{1'b0, 1'b0, 16'h3000, 16'h0000, 16'hA500};

        reset_n = 1'b0;
        bus1.cpu_req = 1'b0; bus1.cpu_we = 1'b0; bus1.cpu_addr = 16'h0; bus1.cpu_wdata = 16'h0;
        bus1.ldr_req = 1'b0; bus1.ldr_we = 1'b0; bus1.ldr_addr = 16'h0; bus1.ldr_wdata = 16'h0;
        bus3.cpu_req = 1'b0; bus3.cpu_we = 1'b0; bus3.cpu_addr = 16'h0; bus3.cpu_wdata = 16'h0;
        bus3.ldr_req = 1'b0; bus3.ldr_we = 1'b0; bus3.ldr_addr = 16'h0; bus3.ldr_wdata = 16'h0;

        // Reset held with random requests: everything must stay zero
        for (int i = 0; i < 4; i++) begin
            bus1.cpu_req = 1'($urandom); bus1.cpu_we = 1'($urandom);
            bus1.cpu_addr = 16'($urandom); bus1.cpu_wdata = 16'($urandom);
            bus1.ldr_req = 1'($urandom); bus1.ldr_we = 1'($urandom);
            bus1.ldr_addr = 16'($urandom); bus1.ldr_wdata = 16'($urandom);
            bus3.ldr_req = 1'($urandom); bus3.cpu_req = 1'($urandom);
            @(negedge clk);
            check_idle_outputs("rst");
        end
        bus1.cpu_req = 1'b0; bus1.ldr_req = 1'b0;
        bus3.cpu_req = 1'b0; bus3.ldr_req = 1'b0;
        #1 reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_outputs("post_rst");
        #1;

        // Table-driven single accesses on the MEM_LAT=1 instance
        for (int i = 0; i < 9; i++) begin
            do_access(vecs[i].is_ldr, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, 1'b1);
        end
        repeat (2) @(negedge clk);
        #1;

        // Loader read on the MEM_LAT=3 instance
        bus3.ldr_we = 1'b0; bus3.ldr_addr = 16'h0002; bus3.ldr_wdata = 16'h0000;
        bus3.ldr_req = 1'b1;
        n = 0;
        while (!bus3.ldr_gnt && n < 20) begin @(negedge clk); n++; end
        check1("lat3_gnt_seen", bus3.ldr_gnt, 1'b1);
        check16("lat3_mem_addr", bus3.mem_addr, 16'h0002);
        g = cyc;
        while (!bus3.ldr_done && n < 40) begin @(negedge clk); n++; end
        check1("lat3_done_seen", bus3.ldr_done, 1'b1);
        check16("lat3_latency", 16'(cyc - g), 16'd3);
        check16("lat3_rdata", bus3.rdata, 16'h3200);
        #1 bus3.ldr_req = 1'b0;
        repeat (2) @(negedge clk);
        check16("lat3_no_we", 16'(we3_cnt), 16'd0);
        check1("lat3_idle", bus3.busy, 1'b0);
        #1;

        // Contention: both ports keep requesting; starvation guard sets the order
        grant_log.delete();
        fork
            begin
                for (int i = 0; i < 8; i++)
                    do_access(1'b1, 1'b0, 16'h0020 + 16'(i), 16'h0000, 16'hA520 + 16'(i), i == 7);
            end
            begin
                for (int j = 0; j < 2; j++)
                    do_access(1'b0, 1'b0, 16'h0040 + 16'(j), 16'h0000, 16'hA540 + 16'(j), j == 1);
            end
        join
        exp_order = "LLLLCLLLLC";
        check16("order_len", 16'(grant_log.size()), 16'd10);
        for (int i = 0; i < 10 && i < grant_log.size(); i++) begin
            check16($sformatf("order_%0d", i), 16'(grant_log[i]), 16'(exp_order[i]));
        end
        repeat (2) @(negedge clk);
        #1;

        // Reset during a loader write: strobe and grant drop at once, no done follows
        bus1.ldr_we = 1'b1; bus1.ldr_addr = 16'h0050; bus1.ldr_wdata = 16'h5555;
        ldr_q.push_back('{we: 1'b1, addr: 16'h0050, wdata: 16'h5555, rdata: 16'hA550});
        bus1.ldr_req = 1'b1;
        n = 0;
        while (!bus1.ldr_gnt && n < 20) begin @(negedge clk); n++; end
        #1;
        check1("abort_we_before", bus1.mem_we, 1'b1);
        reset_n = 1'b0;
        #1;
        check1("abort_mem_we", bus1.mem_we, 1'b0);
        check1("abort_ldr_gnt", bus1.ldr_gnt, 1'b0);
        check1("abort_ldr_done", bus1.ldr_done, 1'b0);
        check1("abort_busy", bus1.busy, 1'b0);
        bus1.ldr_req = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        // The aborted write must not have reached memory
        do_access(1'b1, 1'b0, 16'h0050, 16'h0000, 16'hA550, 1'b1);
        repeat (2) @(negedge clk);
        #1;

`ifdef LC3_ARB_STATS_EN
        reset_n = 1'b0;
        @(negedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++) do_access(1'b0, 1'b0, 16'h0060 + 16'(i), 16'h0000, 16'hA560 + 16'(i), 1'b1);
        for (int i = 0; i < 5; i++) do_access(1'b1, 1'b0, 16'h0070 + 16'(i), 16'h0000, 16'hA570 + 16'(i), 1'b1);
        repeat (2) @(negedge clk);
        check16("stats_cpu", bus1.cpu_grant_cnt, 16'd3);
        check16("stats_ldr", bus1.ldr_grant_cnt, 16'd5);
        check16("stats_cpu_model", bus1.cpu_grant_cnt, 16'(cpu_grants));
        check16("stats_ldr_model", bus1.ldr_grant_cnt, 16'(ldr_grants));
        #1;
`endif

        // Final reset: outputs return to zero
        reset_n = 1'b0;
        #1;
        check_idle_outputs("final_rst");
`ifdef LC3_ARB_STATS_EN
        check16("stats_cpu_rst", bus1.cpu_grant_cnt, 16'd0);
        check16("stats_ldr_rst", bus1.ldr_grant_cnt, 16'd0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop if anything above stalls beyond its own bounds
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
